// File: rtl/ring_digit_mux.sv
// ring_digit_mux: scans a 4-digit seven-segment display from a one-hot ring
// strobe, validates the ring sequence and counts completed scan frames.
module ring_digit_mux #(
  parameter int WIDTH    = 4,
  parameter bit ROT_LEFT = 1'b1,
  parameter int FRAME_W  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic [WIDTH-1:0]     ring_in,
  input  logic [4*WIDTH-1:0]   digits,
  output logic [WIDTH-1:0]     an,
  output logic [6:0]           seg,
  output logic                 err,
  output logic                 frame_tick,
  output logic [FRAME_W-1:0]   frame_cnt
);

  typedef enum logic [1:0] {
    SYNC,
    RUN,
    FAULT
  } state_t;

  localparam logic [WIDTH-1:0] LSB_PAT = WIDTH'(1);
  localparam logic [WIDTH-1:0] MSB_PAT = LSB_PAT << (WIDTH - 1);
  localparam logic [WIDTH-1:0] START   = ROT_LEFT ? LSB_PAT : MSB_PAT;
  localparam logic [WIDTH-1:0] FINISH  = ROT_LEFT ? MSB_PAT : LSB_PAT;

  state_t             state, state_d;
  logic [WIDTH-1:0]   prev, prev_d;
  logic [WIDTH-1:0]   an_d;
  logic [6:0]         seg_d;
  logic               err_d;
  logic               tick_d;
  logic [FRAME_W-1:0] cnt_d;
  logic [WIDTH-1:0]   expected;
  logic [3:0]         nib;

  function automatic logic [6:0] hex7seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  // Next legal strobe: previous strobe rotated one step.
  always_comb begin
    if (ROT_LEFT)
      expected = {prev[WIDTH-2:0], prev[WIDTH-1]};
    else
      expected = {prev[0], prev[WIDTH-1:1]};
  end

  // Nibble picked by the strobe; only consumed when the strobe is one-hot.
  always_comb begin
    nib = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (ring_in[i])
        nib = nib | digits[4*i +: 4];
    end
  end

  // Next state and next registered outputs; blank display by default.
  always_comb begin
    state_d = state;
    prev_d  = prev;
    an_d    = '0;
    seg_d   = '0;
    err_d   = err;
    tick_d  = 1'b0;
    cnt_d   = frame_cnt;
    if (!en) begin
      state_d = SYNC;
    end else begin
      case (state)
        SYNC: begin
          if (ring_in == START) begin
            state_d = RUN;
            prev_d  = ring_in;
            an_d    = ring_in;
            seg_d   = hex7seg(nib);
          end
        end
        RUN: begin
          if (ring_in == expected) begin
            prev_d = ring_in;
            an_d   = ring_in;
            seg_d  = hex7seg(nib);
            if (ring_in == FINISH) begin
              tick_d = 1'b1;
              cnt_d  = frame_cnt + FRAME_W'(1);
            end
          end else begin
            state_d = FAULT;
            err_d   = 1'b1;
          end
        end
        FAULT: begin
          state_d = SYNC;
        end
        default: begin
          state_d = SYNC;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= SYNC;
      prev       <= '0;
      an         <= '0;
      seg        <= '0;
      err        <= 1'b0;
      frame_tick <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      state      <= state_d;
      prev       <= prev_d;
      an         <= an_d;
      seg        <= seg_d;
      err        <= err_d;
      frame_tick <= tick_d;
      frame_cnt  <= cnt_d;
    end
  end

endmodule

// File: tb/tb_ring_digit_mux.sv
// tb_ring_digit_mux: randomized scoreboard bench for ring_digit_mux.
// Expected outputs come from a scan-position model of the display.
module tb_ring_digit_mux;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic [3:0]  ring_in = 4'b0000;
  logic [15:0] digits = 16'h0000;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        err;
  logic        frame_tick;
  logic [7:0]  frame_cnt;

  ring_digit_mux dut (
    .clk(clk),
    .reset(reset),
    .en(en),
    .ring_in(ring_in),
    .digits(digits),
    .an(an),
    .seg(seg),
    .err(err),
    .frame_tick(frame_tick),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       err;
    logic       tick;
    logic [7:0] cnt;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Scan order and glyphs, written straight from the display rules.
  logic [3:0] seq [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
  logic [6:0] glyph [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Model: mode 0 waiting for start, 1 scanning at digit pos, 2 faulted.
  int         mode = 0;
  int         pos = 0;
  logic       m_err = 1'b0;
  logic [7:0] m_cnt = 8'd0;
  int         cur = 0;

  task automatic step_model(input logic r, input logic e,
                            input logic [3:0] rg,
                            input logic [15:0] dg);
    exp_t x;
    x.an = 4'b0000;
    x.seg = 7'h00;
    x.tick = 1'b0;
    if (r) begin
      mode = 0;
      m_err = 1'b0;
      m_cnt = 8'd0;
    end else if (!e) begin
      mode = 0;
    end else if (mode == 0) begin
      if (rg == seq[0]) begin
        mode = 1;
        pos = 0;
        x.an = rg;
        x.seg = glyph[dg[3:0]];
      end
    end else if (mode == 1) begin
      if (rg == seq[(pos + 1) % 4]) begin
        pos = (pos + 1) % 4;
        x.an = rg;
        x.seg = glyph[dg[4*pos +: 4]];
        if (pos == 3) begin
          x.tick = 1'b1;
          m_cnt = m_cnt + 8'd1;
        end
      end else begin
        mode = 2;
        m_err = 1'b1;
      end
    end else begin
      mode = 0;
    end
    x.err = m_err;
    x.cnt = m_cnt;
    q.push_back(x);
  endtask

  task automatic cyc(input logic r, input logic e,
                     input logic [3:0] rg, input logic [15:0] dg);
    @(negedge clk);
    reset = r;
    en = e;
    ring_in = rg;
    digits = dg;
    step_model(r, e, rg, dg);
  endtask

  task automatic legal(input logic e, input logic [15:0] dg);
    cyc(1'b0, e, seq[cur], dg);
    cur = (cur + 1) % 4;
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++)
      cyc(1'b1, 1'b0, 4'b0000, 16'h0000);
    cur = 0;
  endtask

  task automatic frames(input int n, input logic rnd);
    for (int i = 0; i < 4 * n; i++)
      legal(1'b1, rnd ? 16'($urandom) : 16'h8A10);
  endtask

  // Monitor: one registered output set per clock, popped in order.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        checks++;
        if (an !== x.an || seg !== x.seg || err !== x.err ||
            frame_tick !== x.tick || frame_cnt !== x.cnt) begin
          errors++;
          $display("FAIL outputs @%0t: an=%b seg=%h err=%b tick=%b cnt=%0d required an=%b seg=%h err=%b tick=%b cnt=%0d",
                   $time, an, seg, err, frame_tick, frame_cnt,
                   x.an, x.seg, x.err, x.tick, x.cnt);
        end
      end
    end
  end

  initial begin
    int r;
    do_reset(2);
    // Junk before the first start pattern keeps the display blank.
    cyc(1'b0, 1'b1, 4'b0100, 16'h8A10);
    cyc(1'b0, 1'b1, 4'b0000, 16'h8A10);
    cyc(1'b0, 1'b1, 4'b0010, 16'h8A10);
    frames(3, 1'b0);
    frames(20, 1'b1);
    // Illegal two-hot strobe mid-scan, then the sequence resumes.
    legal(1'b1, 16'h1234);
    legal(1'b1, 16'h1234);
    cyc(1'b0, 1'b1, 4'b0110, 16'h1234);
    for (int i = 0; i < 10; i++)
      legal(1'b1, 16'($urandom));
    // Skipped position.
    cur = 0;
    legal(1'b1, 16'hCDEF);
    cur = 2;
    for (int i = 0; i < 10; i++)
      legal(1'b1, 16'($urandom));
    // Clean restart, then en dropped for three cycles mid-scan.
    do_reset(1);
    legal(1'b1, 16'h5678);
    legal(1'b1, 16'h5678);
    for (int i = 0; i < 3; i++)
      legal(1'b0, 16'h5678);
    for (int i = 0; i < 13; i++)
      legal(1'b1, 16'($urandom));
    // Long clean run to wrap the frame counter.
    do_reset(1);
    frames(260, 1'b1);
    // Random mix of legal strobes, glitches, skips and en drops.
    for (int i = 0; i < 800; i++) begin
      r = $urandom_range(0, 99);
      if (r < 3) begin
        legal(1'b0, 16'($urandom));
      end else if (r < 6) begin
        cyc(1'b0, 1'b1, 4'($urandom_range(0, 15)), 16'($urandom));
      end else if (r < 8) begin
        cur = (cur + 1) % 4;
        legal(1'b1, 16'($urandom));
      end else begin
        legal(1'b1, 16'($urandom));
      end
    end
    // Reset while running with err set.
    do_reset(1);
    frames(2, 1'b1);
    cyc(1'b0, 1'b1, 4'b1100, 16'hFFFF);
    for (int i = 0; i < 5; i++)
      legal(1'b1, 16'($urandom));
    do_reset(1);
    frames(2, 1'b1);
    @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
